// File: rtl/mem_bus_slave.sv
// mem_bus_slave
//   Word-addressed memory on the CPU system bus. It answers read and write
//   strobes from the bus master with OK, EN (no memory / protocol error) or
//   PE (parity error on read). It uses a four-phase handshake: the response
//   is held until both strobes are removed, and one dead clock follows
//   before the next access is accepted.
//
//   Optional feature macro: MEM_PARITY_EN. When it is defined, each stored
//   word carries an odd-parity bit and reads can answer PE. When it is
//   undefined, the array is 16 bits wide and rpe_ stays high.
//
// Ports (all bus signals are active-low):
//   __clk  in   1   system clock
//   __rst  in   1   synchronous reset, active-high
//   dr_    in   1   read strobe
//   dw_    in   1   write strobe
//   dnb_   in   4   block number
//   dad_   in   16  word address. Bus bit 0 (the MSB) is dad_[15], so the
//                   page nibble is dad_[15:12].
//   ddt_   in   16  write data
//   rok_   out  1   access OK
//   ren_   out  1   no memory / protocol error
//   rpe_   out  1   parity error on read
//   rdt_   out  16  read data; 16'hffff when not driving
module mem_bus_slave #(
   parameter logic [3:0] MEM_NB    = 4'd0,
   parameter logic [3:0] PAGE_BASE = 4'd0,
   parameter int         PAGES     = 2,
   parameter int         LATENCY   = 2
) (
   input  logic        __clk,
   input  logic        __rst,
   input  logic        dr_,
   input  logic        dw_,
   input  logic [3:0]  dnb_,
   input  logic [15:0] dad_,
   input  logic [15:0] ddt_,
   output logic        rok_,
   output logic        ren_,
   output logic        rpe_,
   output logic [15:0] rdt_
);

   localparam int IW    = $clog2(PAGES) + 12;
   localparam int DEPTH = PAGES * 4096;
`ifdef MEM_PARITY_EN
   localparam int MW = 17;
`else
   localparam int MW = 16;
`endif
   localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
   localparam logic [4:0] PAGES_W = 5'(PAGES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

   // Odd parity: the stored 17-bit word always has an odd number of ones.
   function automatic logic odd_par(input logic [15:0] w);
      return ~(^w);
   endfunction

   logic [MW-1:0] mem_q [DEPTH];

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   data_q, data_d;
   logic          sel_q, sel_d;
   logic          is_rd_q, is_rd_d;
   logic          is_wr_q, is_wr_d;
   logic          rok_q, rok_d;
   logic          ren_q, ren_d;
   logic          rpe_q, rpe_d;
   logic [15:0]   rdt_q, rdt_d;

   logic [3:0]    page_off_s;
   logic          sel_s;
   logic [IW-1:0] idx_s;
   logic [MW-1:0] rd_word_s;
   logic          mem_we_s;

   // Address decode. The page offset wraps in 4 bits, so pages below
   // PAGE_BASE become large offsets and fail the range test.
   always_comb begin
      page_off_s = (~dad_[15:12]) - PAGE_BASE;
      sel_s      = ((~dnb_) == MEM_NB) && ({1'b0, page_off_s} < PAGES_W);
      idx_s      = IW'({page_off_s, ~dad_[11:0]});
   end

   // FSM and response generation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      data_d    = data_q;
      sel_d     = sel_q;
      is_rd_d   = is_rd_q;
      is_wr_d   = is_wr_q;
      rok_d     = rok_q;
      ren_d     = ren_q;
      rpe_d     = rpe_q;
      rdt_d     = rdt_q;
      mem_we_s  = 1'b0;
      rd_word_s = mem_q[idx_q];
      case (state_q)
         S_IDLE: begin
            if (!dr_ || !dw_) begin
               // Address, data and op are captured once, here only.
               idx_d   = idx_s;
               data_d  = ~ddt_;
               sel_d   = sel_s;
               is_rd_d = ~dr_;
               is_wr_d = ~dw_;
               cnt_d   = LAT_M1;
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (dr_ && dw_) begin
               // The master withdrew its strobe: no write and no response.
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               if (!sel_q || (is_rd_q && is_wr_q)) begin
                  ren_d = 1'b0;
`ifdef MEM_PARITY_EN
               end else if (is_rd_q && ((^rd_word_s) == 1'b0)) begin
                  rpe_d = 1'b0;
                  rdt_d = ~rd_word_s[15:0];
`endif
               end else begin
                  rok_d = 1'b0;
                  if (is_rd_q) begin
                     rdt_d = ~rd_word_s[15:0];
                  end else begin
                     mem_we_s = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            if (dr_ && dw_) begin
               rok_d   = 1'b1;
               ren_d   = 1'b1;
               rpe_d   = 1'b1;
               rdt_d   = 16'hffff;
               state_d = S_REL;
            end else begin
               state_d = S_ACK;
            end
         end
         S_REL: begin
            // Dead clock: a strobe that is still low here is not sampled.
            state_d = S_IDLE;
         end
         default: begin
            rok_d   = 1'b1;
            ren_d   = 1'b1;
            rpe_d   = 1'b1;
            rdt_d   = 16'hffff;
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge __clk) begin
      if (__rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         data_q  <= 16'h0000;
         sel_q   <= 1'b0;
         is_rd_q <= 1'b0;
         is_wr_q <= 1'b0;
         rok_q   <= 1'b1;
         ren_q   <= 1'b1;
         rpe_q   <= 1'b1;
         rdt_q   <= 16'hffff;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         is_rd_q <= is_rd_d;
         is_wr_q <= is_wr_d;
         rok_q   <= rok_d;
         ren_q   <= ren_d;
         rpe_q   <= rpe_d;
         rdt_q   <= rdt_d;
      end
   end

   // Storage array. It is not cleared by reset, and a write that coincides
   // with reset is dropped.
   always_ff @(posedge __clk) begin
      if (mem_we_s && !__rst) begin
`ifdef MEM_PARITY_EN
         mem_q[idx_q] <= {odd_par(data_q), data_q};
`else
         mem_q[idx_q] <= data_q;
`endif
      end
   end

   assign rok_ = rok_q;
   assign ren_ = ren_q;
   assign rpe_ = rpe_q;
   assign rdt_ = rdt_q;

endmodule

// File: tb/tb_mem_bus_slave.sv
module tb_mem_bus_slave;

   localparam int LAT = 2;
   localparam logic [2:0] R_OK   = 3'b011;  // {rok_, ren_, rpe_}
   localparam logic [2:0] R_EN   = 3'b101;
   localparam logic [2:0] R_PE   = 3'b110;
   localparam logic [2:0] R_NONE = 3'b111;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_BOTH = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        dr_, dw_;
   logic [3:0]  dnb_;
   logic [15:0] dad_, ddt_;
   logic        rok_, ren_, rpe_;
   logic [15:0] rdt_;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_bus_slave #(
      .MEM_NB(4'd0), .PAGE_BASE(4'd0), .PAGES(2), .LATENCY(LAT)
   ) dut (
      .__clk(clk), .__rst(rst), .dr_(dr_), .dw_(dw_), .dnb_(dnb_),
      .dad_(dad_), .ddt_(ddt_), .rok_(rok_), .ren_(ren_), .rpe_(rpe_),
      .rdt_(rdt_)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [3:0]  nb;
      logic [15:0] addr;
      logic [15:0] data;
      logic [2:0]  resp;
      logic [15:0] rdt;
   } vec_t;

   typedef struct {
      string       name;
      logic [2:0]  resp;
      logic [15:0] rdt;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string name, input logic [1:0] op, input logic [3:0] nb,
                               input logic [15:0] addr, input logic [15:0] data,
                               input logic [2:0] resp, input logic [15:0] rdt);
      vec_t v;
      v.name = name; v.op = op; v.nb = nb; v.addr = addr; v.data = data;
      v.resp = resp; v.rdt = rdt;
      return v;
   endfunction

   // One full handshake: strobe, wait for the response, check it, release.
   task automatic access(input vec_t v);
      exp_t e;
      int   n;
      e.name = v.name; e.resp = v.resp; e.rdt = v.rdt;
      exp_q.push_back(e);
      dnb_ = ~v.nb; dad_ = ~v.addr; ddt_ = ~v.data;
      dr_ = ~v.op[0]; dw_ = ~v.op[1];
      tick();                       // strobe sampled here
      dad_ = 16'h0000; ddt_ = 16'h0000;   // later bus changes must be ignored
      n = 0;
      while ({rok_, ren_, rpe_} == R_NONE && n < 20) begin
         tick();
         n++;
      end
      check({v.name, " latency"}, n, LAT);
      e = exp_q.pop_front();
      check({e.name, " resp"}, {rok_, ren_, rpe_}, e.resp);
      check({e.name, " rdt"}, rdt_, e.rdt);
      dr_ = 1'b1; dw_ = 1'b1;
      tick();
      check({v.name, " release"}, {rok_, ren_, rpe_, rdt_}, {R_NONE, 16'hffff});
      tick();                       // REL -> IDLE
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      rst = 1'b1; dr_ = 1'b1; dw_ = 1'b1; dnb_ = 4'hf; dad_ = 16'hffff; ddt_ = 16'hffff;
      tick(); tick(); tick();
      check("reset outputs", {rok_, ren_, rpe_, rdt_}, {R_NONE, 16'hffff});
      rst = 1'b0;
      tick();

      vecs.push_back(mk("wr 0123",      OP_WR,   4'd0, 16'h0123, 16'hbeef, R_OK, 16'hffff));
      vecs.push_back(mk("rd 0123",      OP_RD,   4'd0, 16'h0123, 16'h0000, R_OK, ~16'hbeef));
      vecs.push_back(mk("wr 1fff",      OP_WR,   4'd0, 16'h1fff, 16'h1234, R_OK, 16'hffff));
      vecs.push_back(mk("wr 2000 unmap", OP_WR,  4'd0, 16'h2000, 16'h5555, R_EN, 16'hffff));
      vecs.push_back(mk("rd 1fff",      OP_RD,   4'd0, 16'h1fff, 16'h0000, R_OK, ~16'h1234));
      vecs.push_back(mk("rd 2000 unmap", OP_RD,  4'd0, 16'h2000, 16'h0000, R_EN, 16'hffff));
      vecs.push_back(mk("wr nb1",       OP_WR,   4'd1, 16'h0123, 16'h0000, R_EN, 16'hffff));
      vecs.push_back(mk("rd 0123 after nb1", OP_RD, 4'd0, 16'h0123, 16'h0000, R_OK, ~16'hbeef));
      vecs.push_back(mk("both strobes", OP_BOTH, 4'd0, 16'h0123, 16'h0000, R_EN, 16'hffff));
      vecs.push_back(mk("rd 0123 after both", OP_RD, 4'd0, 16'h0123, 16'h0000, R_OK, ~16'hbeef));
      vecs.push_back(mk("wr 0000",      OP_WR,   4'd0, 16'h0000, 16'ha5a5, R_OK, 16'hffff));
      vecs.push_back(mk("rd 0000",      OP_RD,   4'd0, 16'h0000, 16'h0000, R_OK, ~16'ha5a5));
      vecs.push_back(mk("rd f123 unmap", OP_RD,  4'd0, 16'hf123, 16'h0000, R_EN, 16'hffff));
      vecs.push_back(mk("wr 1000",      OP_WR,   4'd0, 16'h1000, 16'h0f0f, R_OK, 16'hffff));
      vecs.push_back(mk("rd 1000",      OP_RD,   4'd0, 16'h1000, 16'h0000, R_OK, ~16'h0f0f));
      vecs.push_back(mk("rd nb1 1000",  OP_RD,   4'd1, 16'h1000, 16'h0000, R_EN, 16'hffff));

      foreach (vecs[i]) access(vecs[i]);

      // Hold: the response must stay put while dr_ is held low.
      dnb_ = 4'hf; dad_ = ~16'h0123; dr_ = 1'b0;
      tick();
      n = 0;
      while ({rok_, ren_, rpe_} == R_NONE && n < 20) begin tick(); n++; end
      check("hold latency", n, LAT);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ({rok_, ren_, rpe_, rdt_} !== {R_OK, ~16'hbeef}) bad++;
      end
      check("hold stable cycles bad", bad, 0);
      dr_ = 1'b1;
      tick();
      check("hold release", {rok_, ren_, rpe_, rdt_}, {R_NONE, 16'hffff});
      // Strobe again while in REL: it is only taken once back in IDLE.
      dad_ = ~16'h1fff; dr_ = 1'b0;
      n = 0;
      while ({rok_, ren_, rpe_} == R_NONE && n < 20) begin tick(); n++; end
      check("rel strobe latency", n, LAT + 2);
      check("rel strobe data", {rok_, ren_, rpe_, rdt_}, {R_OK, ~16'h1234});
      dr_ = 1'b1;
      tick(); tick();

      // Abort: one-clock write strobe, then nothing should answer.
      dad_ = ~16'h0000; ddt_ = ~16'h0bad; dw_ = 1'b0;
      tick();
      dw_ = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if ({rok_, ren_, rpe_, rdt_} !== {R_NONE, 16'hffff}) bad++;
      end
      check("abort no response cycles bad", bad, 0);
      access(mk("rd 0000 after abort", OP_RD, 4'd0, 16'h0000, 16'h0000, R_OK, ~16'ha5a5));

      // Reset while the write is waiting: no response, write lost.
      dad_ = ~16'h0000; ddt_ = ~16'h1111; dw_ = 1'b0;
      tick();
      tick();
      rst = 1'b1; dw_ = 1'b1;
      tick();
      check("reset in wait outputs", {rok_, ren_, rpe_, rdt_}, {R_NONE, 16'hffff});
      rst = 1'b0;
      tick(); tick();
      check("after reset no late resp", {rok_, ren_, rpe_, rdt_}, {R_NONE, 16'hffff});
      access(mk("rd 0000 after reset", OP_RD, 4'd0, 16'h0000, 16'h0000, R_OK, ~16'ha5a5));

`ifdef MEM_PARITY_EN
      // Word 5 holds 16'h0001 with its parity bit set, which is even parity.
      dut.mem_q[5] = 17'h1_0001;
      access(mk("rd bad parity", OP_RD, 4'd0, 16'h0005, 16'h0000, R_PE, ~16'h0001));
      access(mk("wr 0005", OP_WR, 4'd0, 16'h0005, 16'h0001, R_OK, 16'hffff));
      access(mk("rd 0005 fixed", OP_RD, 4'd0, 16'h0005, 16'h0000, R_OK, ~16'h0001));
`else
      access(mk("rd 1fff rpe high", OP_RD, 4'd0, 16'h1fff, 16'h0000, R_OK, ~16'h1234));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
